pbutton_array_debouncer: RTL and testbench

Parametrised multi-channel push-button conditioner: synchronises NUM_CH raw button pins into one clock domain, debounces each with its own runtime cycle count, and emits per-channel level/edge events, long-press and auto-repeat pulses, and a wrapping press counter. It replaces per-button single-channel debouncer instances in board test designs and feeds user-interface logic such as counters, menus and 7-segment displays.

---
 rtl/pbutton_array_debouncer_if.sv | 37 +++
 rtl/pbutton_array_debouncer.sv | 185 ++++++++++++++++++
 tb/tb_pbutton_array_debouncer.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pbutton_array_debouncer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pbutton_array_debouncer_if                                           |
// | Pin, threshold and event bundle between the button conditioner and   |
// | its user. master drives pins/thresholds, slave produces events.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface pbutton_array_debouncer_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32,
  parameter int PUSH_W = 4
);
  logic [NUM_CH-1:0]        PB;
  logic [NUM_CH*CNT_W-1:0]  nb_debounce_cycle;
  logic [CNT_W-1:0]         long_press_cycle;
  logic [CNT_W-1:0]         repeat_cycle;
  logic [NUM_CH-1:0]        PB_state_active;
  logic [NUM_CH-1:0]        PB_state_pushed;
  logic [NUM_CH-1:0]        PB_state_released;
  logic [NUM_CH-1:0]        PB_long;
  logic [NUM_CH-1:0]        PB_repeat;
  logic [NUM_CH*PUSH_W-1:0] push_count;
  logic                     any_active;

  modport master (
    output PB, nb_debounce_cycle, long_press_cycle, repeat_cycle,
    input  PB_state_active, PB_state_pushed, PB_state_released,
    input  PB_long, PB_repeat, push_count, any_active
  );

  modport slave (
    input  PB, nb_debounce_cycle, long_press_cycle, repeat_cycle,
    output PB_state_active, PB_state_pushed, PB_state_released,
    output PB_long, PB_repeat, push_count, any_active
  );
endinterface
`default_nettype wire

// File: rtl/pbutton_array_debouncer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pbutton_array_debouncer                                              |
// | Per-channel synchroniser, debounce FSM, long-press/auto-repeat and   |
// | wrapping press counter for NUM_CH push buttons.                      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module pbutton_array_debouncer #(
  parameter int NUM_CH     = 4,
  parameter int CNT_W      = 32,
  parameter int PUSH_W     = 4,
  parameter int ACTIVE_LOW = 1
) (
  input logic                      CLOCK_50,
  input logic                      reset,
  pbutton_array_debouncer_if.slave bus_io
);

  localparam logic [1:0] c_IDLE         = 2'd0;
  localparam logic [1:0] c_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] c_HELD         = 2'd2;
  localparam logic [1:0] c_RELEASE_WAIT = 2'd3;

  localparam logic              c_PIN_IDLE = (ACTIVE_LOW != 0);
  localparam logic [CNT_W-1:0]  c_CNT_ONE  = CNT_W'(1);
  localparam logic [PUSH_W-1:0] c_PUSH_ONE = PUSH_W'(1);

  logic [NUM_CH-1:0]        active_v;
  logic [NUM_CH-1:0]        pushed_v;
  logic [NUM_CH-1:0]        released_v;
  logic [NUM_CH-1:0]        long_v;
  logic [NUM_CH-1:0]        repeat_v;
  logic [NUM_CH*PUSH_W-1:0] push_v;
  logic                     any_active_q;

  logic             long_en;
  logic             rep_en;
  logic [CNT_W-1:0] long_last;
  logic [CNT_W-1:0] rep_last;

  assign long_en   = (bus_io.long_press_cycle != '0);
  assign rep_en    = (bus_io.repeat_cycle != '0);
  assign long_last = bus_io.long_press_cycle - c_CNT_ONE;
  assign rep_last  = bus_io.repeat_cycle - c_CNT_ONE;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [1:0]        sync_q;
    logic              raw;
    logic [CNT_W-1:0]  nb;
    logic [CNT_W-1:0]  n_last;
    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  hold_q, hold_d;
    logic [CNT_W-1:0]  rep_q, rep_d;
    logic              long_done_q, long_done_d;
    logic [PUSH_W-1:0] pcnt_q, pcnt_d;
    logic              active_q, active_d;
    logic              pushed_q, pushed_d;
    logic              released_q, released_d;
    logic              long_q, long_d;
    logic              repeat_q, repeat_d;
    logic              cnt_hit, in_hold, long_hit, rep_phase, rep_hit;

    assign nb     = bus_io.nb_debounce_cycle[i*CNT_W +: CNT_W];
    // A zero debounce length behaves like one cycle, so N-1 is 0 in both cases.
    assign n_last = (nb == '0) ? '0 : nb - c_CNT_ONE;
    assign raw    = sync_q[1] ^ c_PIN_IDLE;

    assign cnt_hit   = (cnt_q == n_last);
    assign in_hold   = (state_q == c_HELD) && raw;
    assign long_hit  = in_hold && long_en && !long_done_q && (hold_q == long_last);
    assign rep_phase = in_hold && long_en && long_done_q && rep_en;
    assign rep_hit   = rep_phase && (rep_q == rep_last);

    always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
        sync_q      <= {2{c_PIN_IDLE}};
        state_q     <= c_IDLE;
        cnt_q       <= '0;
        hold_q      <= '0;
        rep_q       <= '0;
        long_done_q <= 1'b0;
        pcnt_q      <= '0;
        active_q    <= 1'b0;
        pushed_q    <= 1'b0;
        released_q  <= 1'b0;
        long_q      <= 1'b0;
        repeat_q    <= 1'b0;
      end else begin
        sync_q      <= {sync_q[0], bus_io.PB[i]};
        state_q     <= state_d;
        cnt_q       <= cnt_d;
        hold_q      <= hold_d;
        rep_q       <= rep_d;
        long_done_q <= long_done_d;
        pcnt_q      <= pcnt_d;
        active_q    <= active_d;
        pushed_q    <= pushed_d;
        released_q  <= released_d;
        long_q      <= long_d;
        repeat_q    <= repeat_d;
      end
    end

    always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      hold_d      = hold_q;
      rep_d       = rep_q;
      long_done_d = long_done_q;
      case (state_q)
        c_IDLE: begin
          if (raw) begin
            state_d = c_PRESS_WAIT;
            cnt_d   = '0;
          end
        end
        c_PRESS_WAIT: begin
          if (!raw) begin
            state_d = c_IDLE;
          end else if (cnt_hit) begin
            state_d     = c_HELD;
            hold_d      = '0;
            rep_d       = '0;
            long_done_d = 1'b0;
          end else begin
            cnt_d = cnt_q + c_CNT_ONE;
          end
        end
        c_HELD: begin
          if (!raw) begin
            state_d = c_RELEASE_WAIT;
            cnt_d   = '0;
          end else if (long_en && !long_done_q) begin
            if (long_hit) long_done_d = 1'b1;
            else          hold_d      = hold_q + c_CNT_ONE;
          end else if (rep_phase) begin
            rep_d = rep_hit ? '0 : rep_q + c_CNT_ONE;
          end
        end
        default: begin
          // Hold and repeat counters stay frozen while a release is being qualified.
          if (raw) begin
            state_d = c_HELD;
          end else if (cnt_hit) begin
            state_d = c_IDLE;
          end else begin
            cnt_d = cnt_q + c_CNT_ONE;
          end
        end
      endcase
    end

    always_comb begin
      active_d   = (state_d == c_HELD) || (state_d == c_RELEASE_WAIT);
      pushed_d   = (state_q == c_PRESS_WAIT) && raw && cnt_hit;
      released_d = (state_q == c_RELEASE_WAIT) && !raw && cnt_hit;
      long_d     = long_hit;
      repeat_d   = rep_hit;
      pcnt_d     = pushed_d ? pcnt_q + c_PUSH_ONE : pcnt_q;
    end

    assign active_v[i]                  = active_q;
    assign pushed_v[i]                  = pushed_q;
    assign released_v[i]                = released_q;
    assign long_v[i]                    = long_q;
    assign repeat_v[i]                  = repeat_q;
    assign push_v[i*PUSH_W +: PUSH_W]   = pcnt_q;
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) any_active_q <= 1'b0;
    else       any_active_q <= |active_v;
  end

  assign bus_io.PB_state_active   = active_v;
  assign bus_io.PB_state_pushed   = pushed_v;
  assign bus_io.PB_state_released = released_v;
  assign bus_io.PB_long           = long_v;
  assign bus_io.PB_repeat         = repeat_v;
  assign bus_io.push_count        = push_v;
  assign bus_io.any_active        = any_active_q;

endmodule
`default_nettype wire

// File: tb/tb_pbutton_array_debouncer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pbutton_array_debouncer                                           |
// | Scoreboarded bench: expected events queued at stimulus time and      |
// | matched against DUT pulses as they appear. Rev 1.0                   |
// +----------------------------------------------------------------------+
module tb_pbutton_array_debouncer;
  localparam int NUM_CH     = 4;
  localparam int CNT_W      = 32;
  localparam int PUSH_W     = 4;
  localparam int ACTIVE_LOW = 1;

  typedef struct {
    int cyc;
    int kind;
    int ch;
  } ev_t;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   failures;
  int   exp_cnt [NUM_CH];
  ev_t  exp_q [$];

  pbutton_array_debouncer_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PUSH_W(PUSH_W)) bus ();

  pbutton_array_debouncer #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .PUSH_W(PUSH_W), .ACTIVE_LOW(ACTIVE_LOW)
  ) dut (
    .CLOCK_50 (clk),
    .reset    (rst),
    .bus_io   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 0 pushed, 1 released, 2 long, 3 repeat
  always @(negedge clk) begin
    logic [NUM_CH-1:0] v;
    ev_t e;
    for (int k = 0; k < 4; k++) begin
      case (k)
        0:       v = bus.PB_state_pushed;
        1:       v = bus.PB_state_released;
        2:       v = bus.PB_long;
        default: v = bus.PB_repeat;
      endcase
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (v[ch] === 1'b1) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL event_unexpected: got kind=%0d ch=%0d cyc=%0d, required no event", k, ch, cyc);
          end else begin
            e = exp_q.pop_front();
            if (e.cyc != cyc || e.kind != k || e.ch != ch) begin
              failures++;
              $display("FAIL event_match: got kind=%0d ch=%0d cyc=%0d, required kind=%0d ch=%0d cyc=%0d",
                       k, ch, cyc, e.kind, e.ch, e.cyc);
            end
          end
        end
      end
    end
  end

  task automatic expect_ev(input int t, input int k, input int ch);
    ev_t e;
    e.cyc = t; e.kind = k; e.ch = ch;
    exp_q.push_back(e);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic set_pin(input int ch, input bit pressed);
    bus.PB[ch] = (ACTIVE_LOW != 0) ? !pressed : pressed;
  endtask

  task automatic set_n(input int ch, input int n);
    bus.nb_debounce_cycle[ch*CNT_W +: CNT_W] = n;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.PB_state_active, bus.PB_state_pushed, bus.PB_state_released,
         bus.PB_long, bus.PB_repeat, bus.any_active} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got %h, required 0",
               {bus.PB_state_active, bus.PB_state_pushed, bus.PB_state_released,
                bus.PB_long, bus.PB_repeat, bus.any_active});
    end
    checks++;
    if (bus.push_count !== '0) begin
      failures++;
      $display("FAIL reset_push_count: got %h, required 0", bus.push_count);
    end
    rst = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (bus.PB_state_active !== '0 || bus.push_count !== '0) begin
      failures++;
      $display("FAIL idle_after_reset: got active=%h count=%h, required 0/0",
               bus.PB_state_active, bus.push_count);
    end
  endtask

  task automatic test_clean_press();
    int c, r;
    c = cyc;
    set_pin(0, 1'b1);
    expect_ev(c + 7, 0, 0);
    wait_until(c + 6);
    checks++;
    if (bus.PB_state_active[0] !== 1'b0) begin
      failures++;
      $display("FAIL press_early: got active=%b, required 0", bus.PB_state_active[0]);
    end
    wait_until(c + 7);
    exp_cnt[0] = (exp_cnt[0] + 1) % (1 << PUSH_W);
    checks++;
    if (bus.PB_state_active[0] !== 1'b1 || bus.push_count[3:0] !== 4'(exp_cnt[0])) begin
      failures++;
      $display("FAIL press_state: got active=%b count=%0d, required 1/%0d",
               bus.PB_state_active[0], bus.push_count[3:0], exp_cnt[0]);
    end
    checks++;
    if (bus.any_active !== 1'b0) begin
      failures++;
      $display("FAIL any_active_lag: got %b, required 0", bus.any_active);
    end
    @(negedge clk);
    checks++;
    if (bus.any_active !== 1'b1) begin
      failures++;
      $display("FAIL any_active_set: got %b, required 1", bus.any_active);
    end
    wait_until(c + 15);
    r = cyc;
    set_pin(0, 1'b0);
    expect_ev(r + 7, 1, 0);
    wait_until(r + 6);
    checks++;
    if (bus.PB_state_active[0] !== 1'b1) begin
      failures++;
      $display("FAIL release_early: got active=%b, required 1", bus.PB_state_active[0]);
    end
    wait_until(r + 7);
    checks++;
    if (bus.PB_state_active[0] !== 1'b0) begin
      failures++;
      $display("FAIL release_state: got active=%b, required 0", bus.PB_state_active[0]);
    end
    // zero debounce length acts as one cycle
    set_n(1, 0);
    wait_until(r + 10);
    c = cyc;
    set_pin(1, 1'b1);
    expect_ev(c + 4, 0, 1);
    exp_cnt[1] = (exp_cnt[1] + 1) % (1 << PUSH_W);
    wait_until(c + 8);
    r = cyc;
    set_pin(1, 1'b0);
    expect_ev(r + 4, 1, 1);
    wait_until(r + 7);
    set_n(1, 4);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL clean_press_pending: got %0d events missing, required 0", exp_q.size());
    end
  endtask

  task automatic test_bounce();
    int c, r;
    repeat (3) begin
      set_pin(1, 1'b1);
      repeat (3) @(negedge clk);
      set_pin(1, 1'b0);
      repeat (4) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (bus.push_count[7:4] !== 4'(exp_cnt[1]) || bus.PB_state_active[1] !== 1'b0) begin
      failures++;
      $display("FAIL bounce_ignored: got count=%0d active=%b, required %0d/0",
               bus.push_count[7:4], bus.PB_state_active[1], exp_cnt[1]);
    end
    c = cyc;
    set_pin(1, 1'b1);
    expect_ev(c + 7, 0, 1);
    exp_cnt[1] = (exp_cnt[1] + 1) % (1 << PUSH_W);
    wait_until(c + 12);
    r = cyc;
    set_pin(1, 1'b0);
    expect_ev(r + 7, 1, 1);
    wait_until(r + 9);
    checks++;
    if (bus.push_count[7:4] !== 4'(exp_cnt[1]) || exp_q.size() != 0) begin
      failures++;
      $display("FAIL bounce_stable: got count=%0d pending=%0d, required %0d/0",
               bus.push_count[7:4], exp_q.size(), exp_cnt[1]);
    end
  endtask

  task automatic test_long_repeat(input int lc, input int rc, input int hold);
    int c, p, r;
    bus.long_press_cycle = lc;
    bus.repeat_cycle     = rc;
    c = cyc;
    p = c + 7;
    r = p + hold;
    set_pin(0, 1'b1);
    expect_ev(p, 0, 0);
    if (lc != 0 && p + lc <= r + 2) begin
      expect_ev(p + lc, 2, 0);
      if (rc != 0)
        for (int t = p + lc + rc; t <= r + 2; t += rc) expect_ev(t, 3, 0);
    end
    expect_ev(r + 7, 1, 0);
    exp_cnt[0] = (exp_cnt[0] + 1) % (1 << PUSH_W);
    wait_until(r);
    set_pin(0, 1'b0);
    wait_until(r + 9);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL long_repeat_pending L=%0d R=%0d: got %0d missing, required 0", lc, rc, exp_q.size());
    end
    bus.long_press_cycle = 0;
    bus.repeat_cycle     = 0;
  endtask

  task automatic test_release_bounce();
    int c, p, b, r, te;
    bus.long_press_cycle = 10;
    bus.repeat_cycle     = 6;
    c = cyc;
    p = c + 7;
    b = p + 18;
    r = p + 40;
    set_pin(2, 1'b1);
    expect_ev(p, 0, 2);
    expect_ev(p + 10, 2, 2);
    // the one-cycle glitch stalls the repeat counter for two cycles
    for (int t = p + 16; ; t += 6) begin
      te = (t >= b + 3) ? t + 2 : t;
      if (te > r + 2) break;
      expect_ev(te, 3, 2);
    end
    expect_ev(r + 7, 1, 2);
    exp_cnt[2] = (exp_cnt[2] + 1) % (1 << PUSH_W);
    wait_until(b);
    set_pin(2, 1'b0);
    @(negedge clk);
    set_pin(2, 1'b1);
    wait_until(b + 4);
    checks++;
    if (bus.PB_state_active[2] !== 1'b1) begin
      failures++;
      $display("FAIL glitch_active: got %b, required 1", bus.PB_state_active[2]);
    end
    wait_until(r);
    set_pin(2, 1'b0);
    wait_until(r + 9);
    checks++;
    if (exp_q.size() != 0 || bus.push_count[11:8] !== 4'(exp_cnt[2])) begin
      failures++;
      $display("FAIL release_bounce: got pending=%0d count=%0d, required 0/%0d",
               exp_q.size(), bus.push_count[11:8], exp_cnt[2]);
    end
    bus.long_press_cycle = 0;
    bus.repeat_cycle     = 0;
  endtask

  task automatic test_multi_wrap();
    int c, r;
    c = cyc;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      set_pin(ch, 1'b1);
      expect_ev(c + 7, 0, ch);
      exp_cnt[ch] = (exp_cnt[ch] + 1) % (1 << PUSH_W);
    end
    wait_until(c + 7);
    checks++;
    if (bus.PB_state_pushed !== 4'hF || bus.PB_state_active !== 4'hF) begin
      failures++;
      $display("FAIL multi_push: got pushed=%h active=%h, required f/f",
               bus.PB_state_pushed, bus.PB_state_active);
    end
    wait_until(c + 12);
    r = cyc;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      set_pin(ch, 1'b0);
      expect_ev(r + 7, 1, ch);
    end
    wait_until(r + 9);
    repeat (17) begin
      c = cyc;
      set_pin(2, 1'b1);
      expect_ev(c + 7, 0, 2);
      exp_cnt[2] = (exp_cnt[2] + 1) % (1 << PUSH_W);
      wait_until(c + 8);
      r = cyc;
      set_pin(2, 1'b0);
      expect_ev(r + 7, 1, 2);
      wait_until(r + 8);
    end
    checks++;
    if (bus.push_count !== {4'(exp_cnt[3]), 4'(exp_cnt[2]), 4'(exp_cnt[1]), 4'(exp_cnt[0])}) begin
      failures++;
      $display("FAIL push_wrap: got %h, required %0d/%0d/%0d/%0d",
               bus.push_count, exp_cnt[3], exp_cnt[2], exp_cnt[1], exp_cnt[0]);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL multi_pending: got %0d missing, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid_held();
    int c, d, r;
    c = cyc;
    set_pin(3, 1'b1);
    expect_ev(c + 7, 0, 3);
    wait_until(c + 10);
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.PB_state_active, bus.PB_state_pushed, bus.PB_long,
         bus.push_count, bus.any_active} !== '0) begin
      failures++;
      $display("FAIL async_reset: got active=%h count=%h any=%b, required 0",
               bus.PB_state_active, bus.push_count, bus.any_active);
    end
    for (int ch = 0; ch < NUM_CH; ch++) exp_cnt[ch] = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    d = cyc;
    expect_ev(d + 7, 0, 3);
    exp_cnt[3] = 1;
    wait_until(d + 6);
    checks++;
    if (bus.PB_state_active[3] !== 1'b0) begin
      failures++;
      $display("FAIL redebounce_early: got active=%b, required 0", bus.PB_state_active[3]);
    end
    wait_until(d + 7);
    checks++;
    if (bus.push_count !== 16'h1000 || bus.PB_state_active[3] !== 1'b1) begin
      failures++;
      $display("FAIL redebounce: got count=%h active=%b, required 1000/1",
               bus.push_count, bus.PB_state_active[3]);
    end
    r = d + 10;
    wait_until(r);
    set_pin(3, 1'b0);
    expect_ev(r + 7, 1, 3);
    wait_until(r + 9);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL reset_pending: got %0d missing, required 0", exp_q.size());
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;
    for (int ch = 0; ch < NUM_CH; ch++) exp_cnt[ch] = 0;
    rst                  = 1'b1;
    bus.PB               = (ACTIVE_LOW != 0) ? '1 : '0;
    bus.long_press_cycle = 0;
    bus.repeat_cycle     = 0;
    for (int ch = 0; ch < NUM_CH; ch++) set_n(ch, 4);

    test_reset();
    test_clean_press();
    test_bounce();
    test_long_repeat(20, 5, 60);
    test_long_repeat(20, 0, 40);
    test_long_repeat(0, 5, 30);
    test_release_bounce();
    test_multi_wrap();
    test_reset_mid_held();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
